// File: rtl/line_rasterizer.sv
// Bresenham line rasterizer: accepts one {x0,y0,x1,y1} descriptor and streams
// every pixel from point 0 to point 1 on a valid/ready pixel interface.
module line_rasterizer #(
    parameter int LINE_BITS = 7
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   line_valid_i,
    output logic                   line_ready_o,
    input  logic [4*LINE_BITS-1:0] line_i,
    input  logic                   flush_i,
    output logic                   pix_valid_o,
    input  logic                   pix_ready_i,
    output logic [LINE_BITS-1:0]   pix_x_o,
    output logic [LINE_BITS-1:0]   pix_y_o,
    output logic                   pix_last_o,
    output logic                   busy_o
);
    localparam int W = LINE_BITS;

    typedef enum logic [1:0] {IDLE, SETUP, STEP} state_e;

    state_e              state_q, state_d;
    logic [W-1:0]        x_q, x_d, y_q, y_d, x1_q, x1_d, y1_q, y1_d;
    logic signed [W+1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic                sx_q, sx_d, sy_q, sy_d;   // 1 = step towards smaller coordinate
    logic                pix_valid_q, pix_last_q, busy_q;
    logic                pix_valid_d, pix_last_d, busy_d;

    logic signed [W+2:0] e2, dx_e, dy_e;
    logic [W-1:0]        adx, ady;
    logic                hs, step_x, step_y;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        err_d   = err_q;
        sx_d    = sx_q;
        sy_d    = sy_q;

        e2     = {err_q, 1'b0};
        dx_e   = {dx_q[W+1], dx_q};
        dy_e   = {dy_q[W+1], dy_q};
        step_x = (e2 >= dy_e);
        step_y = (e2 <= dx_e);
        // In SETUP the current point still holds (x0,y0).
        adx    = (x1_q >= x_q) ? x1_q - x_q : x_q - x1_q;
        ady    = (y1_q >= y_q) ? y1_q - y_q : y_q - y1_q;
        hs     = pix_valid_q && pix_ready_i;

        case (state_q)
            IDLE: begin
                if (!flush_i && line_valid_i) begin
                    x_d     = line_i[4*W-1 -: W];
                    y_d     = line_i[3*W-1 -: W];
                    x1_d    = line_i[2*W-1 -: W];
                    y1_d    = line_i[W-1:0];
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    dx_d    = {2'b00, adx};
                    dy_d    = -$signed({2'b00, ady});
                    sx_d    = (x1_q < x_q);
                    sy_d    = (y1_q < y_q);
                    err_d   = dx_d + dy_d;
                    state_d = STEP;
                end
            end
            STEP: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (hs) begin
                    if (pix_last_q) begin
                        state_d = IDLE;
                    end else begin
                        if (step_x) x_d = sx_q ? x_q - 1'b1 : x_q + 1'b1;
                        if (step_y) y_d = sy_q ? y_q - 1'b1 : y_q + 1'b1;
                        err_d = err_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        pix_valid_d = (state_d == STEP);
        busy_d      = (state_d != IDLE);
        pix_last_d  = (state_d == STEP) && (x_d == x1_d) && (y_d == y1_d);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            err_q       <= '0;
            sx_q        <= 1'b0;
            sy_q        <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            err_q       <= err_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            pix_valid_q <= pix_valid_d;
            pix_last_q  <= pix_last_d;
            busy_q      <= busy_d;
        end
    end

    assign line_ready_o = (state_q == IDLE) && !flush_i && !rst_i;
    assign pix_valid_o  = pix_valid_q;
    assign pix_x_o      = x_q;
    assign pix_y_o      = y_q;
    assign pix_last_o   = pix_last_q;
    assign busy_o       = busy_q;
endmodule

// File: tb/tb_line_rasterizer.sv
// Directed bench for line_rasterizer: table of segments with hand-computed
// pixel sequences, plus flush, backpressure and async reset sequences.
module tb_line_rasterizer;
    logic        clk, rst, line_valid, line_ready, flush;
    logic [27:0] line;
    logic        pix_valid, pix_ready, pix_last, busy;
    logic [6:0]  pix_x, pix_y;

    int checks = 0;
    int errors = 0;

    line_rasterizer #(.LINE_BITS(7)) dut (
        .clk_i(clk), .rst_i(rst), .line_valid_i(line_valid), .line_ready_o(line_ready),
        .line_i(line), .flush_i(flush), .pix_valid_o(pix_valid), .pix_ready_i(pix_ready),
        .pix_x_o(pix_x), .pix_y_o(pix_y), .pix_last_o(pix_last), .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] x0, y0, x1, y1;
        int         n;
        int         off;
        bit         diag;
    } seg_t;

    typedef struct {
        logic [6:0] x, y;
        logic       last;
    } pix_t;

    seg_t segs[5];
    pix_t pt[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_seg(input int si, input bit bp, input bit hold_valid);
        seg_t s;
        int k, cyc;
        bit seen, stalled, rdy;
        logic [14:0] held, exp;
        s = segs[si];
        k = 0; cyc = 0; seen = 0; stalled = 0;
        held = '0;
        @(negedge clk);
        line_valid = 1'b1;
        line = {s.x0, s.y0, s.x1, s.y1};
        chk("line_ready_idle", {31'd0, line_ready}, 32'd1);
        @(posedge clk);
        #1 if (!hold_valid) line_valid = 1'b0;
        while (k < s.n && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (hold_valid) chk("line_ready_busy", {31'd0, line_ready}, 32'd0);
            if (pix_valid) begin
                if (!seen) begin
                    chk("first_pix_latency", cyc, 2);
                    seen = 1;
                end
                if (stalled) chk("stall_stable", {17'd0, pix_x, pix_y, pix_last}, {17'd0, held});
                rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                pix_ready = rdy;
                if (rdy) begin
                    if (s.diag) exp = {k[6:0], k[6:0], k == s.n - 1};
                    else        exp = {pt[s.off+k].x, pt[s.off+k].y, pt[s.off+k].last};
                    chk($sformatf("seg%0d_pix%0d", si, k), {17'd0, pix_x, pix_y, pix_last}, {17'd0, exp});
                    k++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held = {pix_x, pix_y, pix_last};
                end
            end
        end
        if (k < s.n) chk($sformatf("seg%0d_timeout", si), k, s.n);
        @(negedge clk);
        pix_ready = 1'b1;
        chk("post_seg_idle", {29'd0, pix_valid, busy, line_ready}, 32'b001);
        line_valid = 1'b0;
    endtask

    initial begin
        int cnt;
        segs[0] = '{x0:0, y0:5, x1:3,   y1:5,   n:4,   off:0,  diag:0};
        segs[1] = '{x0:2, y0:4, x1:0,   y1:0,   n:5,   off:4,  diag:0};
        segs[2] = '{x0:0, y0:0, x1:5,   y1:2,   n:6,   off:9,  diag:0};
        segs[3] = '{x0:9, y0:9, x1:9,   y1:9,   n:1,   off:15, diag:0};
        segs[4] = '{x0:0, y0:0, x1:127, y1:127, n:128, off:0,  diag:1};
        pt[0]  = '{0,5,0}; pt[1]  = '{1,5,0}; pt[2]  = '{2,5,0}; pt[3]  = '{3,5,1};
        pt[4]  = '{2,4,0}; pt[5]  = '{1,3,0}; pt[6]  = '{1,2,0}; pt[7]  = '{0,1,0}; pt[8] = '{0,0,1};
        pt[9]  = '{0,0,0}; pt[10] = '{1,0,0}; pt[11] = '{2,1,0}; pt[12] = '{3,1,0};
        pt[13] = '{4,2,0}; pt[14] = '{5,2,1};
        pt[15] = '{9,9,1};

        rst = 1'b1; line_valid = 1'b0; line = '0; flush = 1'b0; pix_ready = 1'b1;
        #12;
        chk("reset_outputs", {14'd0, pix_valid, busy, pix_last, line_ready, pix_x, pix_y}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("ready_after_reset", {31'd0, line_ready}, 32'd1);

        run_seg(0, 0, 0);
        run_seg(1, 0, 0);
        run_seg(4, 0, 0);
        run_seg(3, 0, 0);
        run_seg(2, 1, 1);

        // Flush on the 3rd pixel of (0,0)->(10,0), then flush wins over a pending descriptor in IDLE.
        @(negedge clk);
        line_valid = 1'b1;
        line = {7'd0, 7'd0, 7'd10, 7'd0};
        @(posedge clk);
        #1 line_valid = 1'b0;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!(pix_valid && pix_x == 7'd2) && cnt < 50);
        chk("flush_reach_pix3", {24'd0, pix_x, pix_valid}, {24'd0, 7'd2, 1'b1});
        flush = 1'b1;
        @(negedge clk);
        chk("flush_to_idle", {30'd0, pix_valid, busy}, 32'd0);
        line_valid = 1'b1;
        line = {7'd2, 7'd4, 7'd0, 7'd0};
        #1 chk("flush_blocks_ready", {31'd0, line_ready}, 32'd0);
        @(negedge clk);
        chk("flush_no_accept", {31'd0, busy}, 32'd0);
        flush = 1'b0;
        line_valid = 1'b0;
        run_seg(1, 0, 0);

        // Async reset while a degenerate segment's only pixel is stalled.
        @(negedge clk);
        line_valid = 1'b1;
        line = {7'd9, 7'd9, 7'd9, 7'd9};
        pix_ready = 1'b0;
        @(posedge clk);
        #1 line_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_step", {28'd0, pix_valid, pix_last, busy, 1'b0}, 32'b1110);
        #2 rst = 1'b1;
        #1 chk("async_rst", {28'd0, pix_valid, busy, pix_last, line_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pix_ready = 1'b1;
        #1 chk("ready_after_rst_pulse", {31'd0, line_ready}, 32'd1);
        @(negedge clk);
        chk("idle_after_rst_pulse", {30'd0, pix_valid, busy}, 32'd0);

        run_seg(2, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end
endmodule
